// File: rtl/keypad_entry_controller.sv
// keypad_entry_controller: debounces keypad digits into a 4-digit MM:SS entry register
// and pulses load to the countdown timer on a qualified start request.
module keypad_entry_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_enable,
  input  logic [3:0] key_digit,
  input  logic       key_validn,
  input  logic       clear_key,
  input  logic       start_key,
  output logic       enc_enablen,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       load,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, SHIFT, WAIT_RELEASE} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [3:0] r_cap, w_cap;
  logic [15:0] r_digits;
  logic r_load, r_start_prev;
  logic w_clear, w_key_ok, w_start;
  assign w_clear = clear_key && entry_enable;
  assign w_key_ok = entry_enable && !key_validn && key_digit == r_cap;
  // start only fires on the rising edge of start_key; a simultaneous clear suppresses it
  assign w_start = start_key && !r_start_prev && entry_enable && r_state == IDLE && |r_digits && !clear_key;
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    w_cap = r_cap;
    unique case (r_state)
      IDLE: if (entry_enable && !key_validn) begin
        w_next = DEBOUNCE;
        w_cap = key_digit;
        w_cnt = CNT_W'(1);
      end
      DEBOUNCE: if (!w_key_ok) w_next = IDLE;
        else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES)) w_next = SHIFT;
        else w_cnt = r_cnt + 1'b1;
      SHIFT: w_next = WAIT_RELEASE;
      WAIT_RELEASE: if (!entry_enable || key_validn) w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_cap <= 4'hF;
      r_digits <= '0;
      r_load <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_cap <= w_cap;
      r_digits <= w_clear ? '0 : (r_state == SHIFT && entry_enable) ? {r_digits[11:0], r_cap} : r_digits;
      r_load <= w_start;
      r_start_prev <= start_key;
    end
  end
  assign {min_tens, min_ones, sec_tens, sec_ones} = r_digits;
  assign load = r_load;
  assign busy = r_state != IDLE;
  assign enc_enablen = !entry_enable;
endmodule

// File: tb/tb_keypad_entry_controller.sv
// tb_keypad_entry_controller: directed and randomized checks of keypad entry against a
// sample-stream reference model of debounce, shift, release, clear and start behaviour.
module tb_keypad_entry_controller;
  localparam int N = 4;
  logic clk = 0, reset = 1, entry_enable = 0, key_validn = 1, clear_key = 0, start_key = 0;
  logic [3:0] key_digit = 4'hF;
  logic enc_enablen, load, busy;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  int n_vec = 0, n_err = 0, n_loads = 0;
  int m_run = 0;
  logic [3:0] m_d = 4'hF;
  logic [15:0] m_dig = '0;
  bit m_pend = 0, m_locked = 0, m_prev = 0, m_load = 0;

  keypad_entry_controller #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .entry_enable(entry_enable), .key_digit(key_digit),
    .key_validn(key_validn), .clear_key(clear_key), .start_key(start_key),
    .enc_enablen(enc_enablen), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .load(load), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A digit is committed once N+1 consecutive identical valid samples are seen while armed;
  // the shift lands one edge later, after which the key must be released before re-arming.
  task automatic model_update();
    bit idle;
    if (reset) begin
      m_dig = '0; m_run = 0; m_pend = 0; m_locked = 0; m_load = 0; m_prev = 0;
    end else begin
      idle = m_run == 0 && !m_pend && !m_locked;
      m_load = start_key && !m_prev && entry_enable && idle && m_dig != 0 && !clear_key;
      m_prev = start_key;
      if (entry_enable && clear_key) m_dig = '0;
      else if (m_pend && entry_enable) m_dig = {m_dig[11:0], m_d};
      if (m_pend) begin m_pend = 0; m_locked = 1; end
      else if (m_locked) begin if (!entry_enable || key_validn) m_locked = 0; end
      else if (!entry_enable || key_validn || (m_run > 0 && key_digit != m_d)) m_run = 0;
      else if (m_run == 0) begin m_run = 1; m_d = key_digit; end
      else if (m_run == N) begin m_run = 0; m_pend = 1; end
      else m_run++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (load) n_loads++;
    check("digits", {min_tens, min_ones, sec_tens, sec_ones}, m_dig);
    check("load", 16'(load), 16'(m_load));
    check("busy", 16'(busy), 16'(m_run > 0 || m_pend || m_locked));
    check("enc_enablen", 16'(enc_enablen), 16'(!entry_enable));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [3:0] d, input int hold, input int rel);
    key_digit = d; key_validn = 0;
    steps(hold);
    key_digit = 4'hF; key_validn = 1;
    steps(rel);
  endtask

  function automatic logic [15:0] dig();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  initial begin
    steps(2);
    check("reset_digits", dig(), 16'h0000);
    check("reset_busy", 16'(busy), 16'h0);
    check("reset_load", 16'(load), 16'h0);
    check("reset_enc", 16'(enc_enablen), 16'h1);
    reset = 0; entry_enable = 1;
    steps(1);
    key_digit = 4'd5; key_validn = 0;
    steps(N + 1);
    check("latency_before", dig(), 16'h0000);
    step();
    check("latency_at", dig(), 16'h0005);
    steps(4);
    key_digit = 4'hF; key_validn = 1;
    steps(2);
    check("single_shift", dig(), 16'h0005);
    press(1, 6, 2); press(2, 6, 2); press(3, 6, 2); press(0, 6, 2);
    check("four_digits", dig(), 16'h1230);
    press(9, 6, 2);
    check("fifth_digit", dig(), 16'h2309);
    clear_key = 1; step(); clear_key = 0;
    check("clear", dig(), 16'h0000);
    press(7, 2, 2); press(7, 6, 2);
    check("bounce", dig(), 16'h0007);
    key_digit = 7; key_validn = 0; steps(2);
    key_digit = 8; steps(3);
    key_digit = 4'hF; key_validn = 1; steps(2);
    check("digit_change", dig(), 16'h0007);
    clear_key = 1; step(); clear_key = 0;
    press(3, 6, 2); press(0, 6, 2);
    check("entry_0030", dig(), 16'h0030);
    n_loads = 0; start_key = 1; steps(5); start_key = 0; steps(2);
    check("start_one_load", 16'(n_loads), 16'd1);
    clear_key = 1; step(); clear_key = 0;
    n_loads = 0; start_key = 1; steps(5); start_key = 0; steps(2);
    check("start_zero_noload", 16'(n_loads), 16'd0);
    press(4, 6, 2);
    n_loads = 0; start_key = 1; clear_key = 1; steps(3); start_key = 0; clear_key = 0; steps(2);
    check("start_clear_noload", 16'(n_loads), 16'd0);
    check("start_clear_dig", dig(), 16'h0000);
    press(1, 6, 2);
    key_digit = 6; key_validn = 0; steps(N + 1);
    check("in_shift", 16'(busy), 16'h1);
    clear_key = 1; step(); clear_key = 0;
    check("clear_in_shift", dig(), 16'h0000);
    step();
    check("wait_release_busy", 16'(busy), 16'h1);
    key_digit = 4'hF; key_validn = 1; steps(2);
    check("released", 16'(busy), 16'h0);
    press(1, 6, 2);
    key_digit = 2; key_validn = 0; steps(2);
    reset = 1; step(); reset = 0;
    check("rst_deb_busy", 16'(busy), 16'h0);
    check("rst_deb_dig", dig(), 16'h0000);
    key_digit = 4'hF; key_validn = 1; steps(2);
    press(3, 8, 0);
    check("pre_rst_wr", 16'(busy), 16'h1);
    reset = 1; step(); reset = 0;
    check("rst_wr_busy", 16'(busy), 16'h0);
    check("rst_wr_dig", dig(), 16'h0000);
    steps(2);
    press(8, 6, 2);
    entry_enable = 0; key_digit = 4; key_validn = 0; clear_key = 1; start_key = 1;
    steps(8);
    check("disabled_enc", 16'(enc_enablen), 16'h1);
    check("disabled_dig", dig(), 16'h0008);
    check("disabled_busy", 16'(busy), 16'h0);
    key_validn = 1; key_digit = 4'hF; clear_key = 0; start_key = 0;
    steps(2);
    for (int s = 0; s < 400; s++) begin
      entry_enable = $urandom_range(0, 9) != 0;
      key_digit = 4'($urandom_range(0, 3) == 0 ? $urandom_range(10, 15) : $urandom_range(0, 9));
      key_validn = $urandom_range(0, 2) == 0;
      clear_key = $urandom_range(0, 19) == 0;
      start_key = $urandom_range(0, 4) == 0;
      reset = $urandom_range(0, 59) == 0;
      step();
      reset = 0;
      steps($urandom_range(0, 7));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_entry_controller.md
Name: keypad_entry_controller

Overview:
- Sequences keypad digit entry for the timer.
- Drives the enable of the keypad priority encoder and takes its BCD digit and active-low valid flag.
- Debounces each press, shifts the accepted digit into a 4-digit MM:SS register, then waits for key release.
- Issues a one-cycle load pulse to the countdown timer when start is requested with a non-zero entry.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a digit must stay stable and valid before it is accepted. Legal range is 1..255.
- CNT_W, 8: width of the internal debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- entry_enable  input  1  high while the system is in programming mode (timer not running).
- key_digit  input  4  BCD digit from the encoder; 4'hF means no key.
- key_validn  input  1  encoder flag, active low; low means key_digit is a legal single key.
- clear_key  input  1  level; clears the entry register.
- start_key  input  1  level; requests a load of the entry into the timer.
- enc_enablen  output  1  encoder enable, active low.
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD entry register.
- load  output  1  one-cycle pulse; the timer captures the four digits on this cycle.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- All state is synchronous to clk; reset has priority over every other input.
- Reset values: state=IDLE, all four digits 0, load=0, busy=0, enc_enablen=1, counter=0, captured digit=4'hF.
- enc_enablen = !entry_enable. It is combinational and independent of state.
- States:
  - IDLE: if entry_enable and !key_validn, capture key_digit, set counter=1, go to DEBOUNCE.
  - DEBOUNCE: if !entry_enable, or key_validn goes high, or key_digit differs from the captured digit, go to IDLE with no shift. If the same digit stays valid, increment the counter. When the counter reaches DEBOUNCE_CYCLES, go to SHIFT.
  - SHIFT: lasts exactly one cycle. min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=captured digit; the old min_tens is discarded. Then go to WAIT_RELEASE.
  - WAIT_RELEASE: stay until key_validn=1 for one cycle, then go to IDLE. A held key produces exactly one shift. If entry_enable drops, go to IDLE immediately.
- Digit latency: when DEBOUNCE_CYCLES=N, the digit appears in sec_ones N+1 cycles after the first cycle key_validn is seen low in IDLE.
- Clear:
  - When clear_key=1 and entry_enable=1, all digits go to 0 on the next edge.
  - Clear overrides a SHIFT in the same cycle, so no digit is inserted.
  - The FSM state is unaffected.
- Start:
  - When start_key=1, entry_enable=1, state=IDLE and the entry is non-zero, assert load for one cycle.
  - load is edge-qualified: an internal start_prev register prevents repeated pulses while start_key is held.
  - If the entry is all zeros, there is no load.
  - If start_key and clear_key are asserted together, clear wins and there is no load.
- No range check on digits. sec_tens>5 is accepted here and normalised by the timer block.
- Multiple simultaneous keys make key_validn=1. This is treated as no key: the FSM aborts DEBOUNCE, or releases from WAIT_RELEASE.
- When entry_enable=0, the digits hold their values, and clear_key and start_key are ignored.

Test Plan:
- Reset, then entry_enable=1 with key_digit=5 and key_validn=0 held for 10 cycles (N=4) -> sec_ones=5 exactly 5 cycles after the first valid cycle, other digits 0, one shift only.
- Press 1,2,3,0 with release between each -> min_tens=1, min_ones=2, sec_tens=3, sec_ones=0. A fifth press of 9 -> 2,3,0,9.
- key_digit=7 valid for 2 cycles then released (bounce), then 7 again for 6 cycles -> exactly one shift of 7. Digit changes 7->8 during DEBOUNCE -> no shift.
- Entry 00:30 with start_key held 5 cycles -> load high for exactly 1 cycle. Entry 00:00 with start_key -> load never asserts. start_key and clear_key together -> digits 0, no load.
- clear_key asserted in the SHIFT cycle -> all digits 0, digit not inserted, FSM proceeds to WAIT_RELEASE.
- reset asserted in DEBOUNCE and in WAIT_RELEASE -> next cycle: state IDLE, digits 0, busy=0. entry_enable=0 -> enc_enablen=1 and key input has no effect.
